// File: rtl/led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// led_pattern_ctrl
//
// N-channel LED pattern engine on the OPB register bus. A programmable divider
// derives a tick from OPB_CLK. The tick advances one of four patterns: bouncing
// chase, manual, alternating or blink. The raw pattern is gated by the global
// enable and a PWM dimmer, XORed with a per-channel polarity mask, and then
// registered onto the LEDs.
//
// Ports:
//   OPB_CLK   in   1      sole clock, rising edge
//   OPB_RST   in   1      asynchronous, active-high reset
//   OPB_DI    in   32     write data
//   OPB_DO    out  32     read data (combinational, 0 when not reading/unmapped)
//   OPB_ADDR  in   3      register select
//   OPB_RE    in   1      read strobe
//   OPB_WE    in   1      write strobe, register updates on the strobed edge
//   LED_OUT   out  N_LED  registered LED drives
//   TICK_SQ   out  1      square wave, toggles on every tick
//
// Register map: 0 CNTRL {enable, mode[1:0]}, 1 CLKDIV, 2 PATTERN (RO),
// 3 STATE {dir, pos[7:0]} (RO), 4 MANUAL, 5 INVERT, 6 DUTY, 7 TICKCNT (RO).
// -----------------------------------------------------------------------------
module led_pattern_ctrl #(
    parameter int                   N_LED       = 15,
    parameter int                   DIV_WIDTH   = 32,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(2000000),
    parameter int                   PWM_WIDTH   = 8,
    parameter logic [31:0]          MANUAL_RST  = 32'h2AA
) (
    input  logic             OPB_CLK,
    input  logic             OPB_RST,
    input  logic [31:0]      OPB_DI,
    output logic [31:0]      OPB_DO,
    input  logic [2:0]       OPB_ADDR,
    input  logic             OPB_RE,
    input  logic             OPB_WE,
    output logic [N_LED-1:0] LED_OUT,
    output logic             TICK_SQ
);

    localparam logic [1:0] MODE_CHASE  = 2'd0;
    localparam logic [1:0] MODE_MANUAL = 2'd1;
    localparam logic [1:0] MODE_ALT    = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam logic [2:0] ADDR_CNTRL   = 3'd0;
    localparam logic [2:0] ADDR_CLKDIV  = 3'd1;
    localparam logic [2:0] ADDR_PATTERN = 3'd2;
    localparam logic [2:0] ADDR_STATE   = 3'd3;
    localparam logic [2:0] ADDR_MANUAL  = 3'd4;
    localparam logic [2:0] ADDR_INVERT  = 3'd5;
    localparam logic [2:0] ADDR_DUTY    = 3'd6;
    localparam logic [2:0] ADDR_TICKCNT = 3'd7;

    localparam logic [7:0] LAST_POS = 8'(N_LED - 1);

    // Alternating base mask: bit 0 set, every other bit after it.
    function automatic logic [N_LED-1:0] alt_mask();
        logic [N_LED-1:0] m;
        for (int i = 0; i < N_LED; i++) m[i] = ((i % 2) == 0);
        return m;
    endfunction

    localparam logic [N_LED-1:0] ALT_MASK = alt_mask();

    // Programmable registers
    logic [1:0]           mode;
    logic                 enable;
    logic [DIV_WIDTH-1:0] clkdiv;
    logic [N_LED-1:0]     manual;
    logic [N_LED-1:0]     invert;
    logic [PWM_WIDTH-1:0] duty;
    logic [31:0]          tickcnt;

    // Engine state
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [7:0]           pos;
    logic                 dir;
    logic                 phase;

    logic [7:0]           pos_nxt;
    logic                 dir_nxt;
    logic [N_LED-1:0]     pattern;
    logic                 div_wrap;
    logic                 tick;
    logic                 gate;

    logic wr_cntrl, wr_clkdiv, wr_manual, wr_invert, wr_duty, mode_change;

    assign wr_cntrl    = OPB_WE && (OPB_ADDR == ADDR_CNTRL);
    assign wr_clkdiv   = OPB_WE && (OPB_ADDR == ADDR_CLKDIV);
    assign wr_manual   = OPB_WE && (OPB_ADDR == ADDR_MANUAL);
    assign wr_invert   = OPB_WE && (OPB_ADDR == ADDR_INVERT);
    assign wr_duty     = OPB_WE && (OPB_ADDR == ADDR_DUTY);
    assign mode_change = wr_cntrl && (OPB_DI[1:0] != mode);

    // CLKDIV of 0 or 1 wraps every cycle. A CLKDIV write restarts the divider
    // and suppresses the tick that would otherwise fall on that edge.
    assign div_wrap = (clkdiv <= DIV_WIDTH'(1)) || (div_cnt == clkdiv - DIV_WIDTH'(1));
    assign tick     = div_wrap && !wr_clkdiv;

    // Full-scale duty holds the gate open; otherwise it is a compare against
    // the free-running counter, so DUTY=0 closes it completely.
    assign gate = (&duty) || (pwm_cnt < duty);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        if (N_LED > 1) begin
            if (!dir) begin
                pos_nxt = pos + 8'd1;
                dir_nxt = (pos_nxt == LAST_POS);
            end else begin
                pos_nxt = pos - 8'd1;
                dir_nxt = (pos_nxt != 8'd0);
            end
        end
    end

    always_comb begin
        pattern = '0;
        case (mode)
            MODE_CHASE:  pattern = N_LED'(1) << pos;
            MODE_MANUAL: pattern = manual;
            MODE_ALT:    pattern = phase ? ~ALT_MASK : ALT_MASK;
            MODE_BLINK:  pattern = phase ? '1 : '0;
            default:     pattern = '0;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments, so every
    // right-hand side sees pre-edge values regardless of statement order.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            mode    <= MODE_CHASE;
            enable  <= 1'b1;
            clkdiv  <= DEFAULT_DIV;
            manual  <= MANUAL_RST[N_LED-1:0];
            invert  <= '0;
            duty    <= '1;
        end else begin
            if (wr_cntrl) begin
                mode   <= OPB_DI[1:0];
                enable <= OPB_DI[2];
            end
            if (wr_clkdiv) clkdiv <= OPB_DI[DIV_WIDTH-1:0];
            if (wr_manual) manual <= OPB_DI[N_LED-1:0];
            if (wr_invert) invert <= OPB_DI[N_LED-1:0];
            if (wr_duty)   duty   <= OPB_DI[PWM_WIDTH-1:0];
        end
    end

    // Divider, tick counter and square wave run regardless of enable.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
            tickcnt <= '0;
            TICK_SQ <= 1'b0;
        end else begin
            div_cnt <= (wr_clkdiv || div_wrap) ? '0 : div_cnt + DIV_WIDTH'(1);
            pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
            if (tick) begin
                tickcnt <= tickcnt + 32'd1;
                TICK_SQ <= ~TICK_SQ;
            end
        end
    end

    // A mode change restarts the pattern and wins over a coincident tick.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            pos   <= '0;
            dir   <= 1'b0;
            phase <= 1'b0;
        end else if (mode_change) begin
            pos   <= '0;
            dir   <= 1'b0;
            phase <= 1'b0;
        end else if (tick && enable) begin
            case (mode)
                MODE_CHASE: begin
                    pos <= pos_nxt;
                    dir <= dir_nxt;
                end
                MODE_ALT, MODE_BLINK: phase <= ~phase;
                default: ;
            endcase
        end
    end

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) LED_OUT <= '0;
        else         LED_OUT <= (pattern & {N_LED{enable & gate}}) ^ invert;
    end

    always_comb begin
        OPB_DO = '0;
        if (OPB_RE) begin
            case (OPB_ADDR)
                ADDR_CNTRL:   OPB_DO = {29'd0, enable, mode};
                ADDR_CLKDIV:  OPB_DO = 32'(clkdiv);
                ADDR_PATTERN: OPB_DO = 32'(pattern);
                ADDR_STATE:   OPB_DO = {23'd0, dir, pos};
                ADDR_MANUAL:  OPB_DO = 32'(manual);
                ADDR_INVERT:  OPB_DO = 32'(invert);
                ADDR_DUTY:    OPB_DO = 32'(duty);
                ADDR_TICKCNT: OPB_DO = tickcnt;
                default:      OPB_DO = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_ctrl
//
// Directed and random stimulus for led_pattern_ctrl with N_LED=4 and
// PWM_WIDTH=4. A reference model tracks the architectural state. The chase
// position comes from a step count folded onto a triangle wave. ALT/BLINK
// come from a phase bit, and the PWM gate from the cycle count modulo 16.
// -----------------------------------------------------------------------------
module tb_led_pattern_ctrl;

    localparam int N       = 4;
    localparam int DEF_DIV = 2000000;

    logic        OPB_CLK;
    logic        OPB_RST;
    logic [31:0] OPB_DI;
    logic [31:0] OPB_DO;
    logic [2:0]  OPB_ADDR;
    logic        OPB_RE;
    logic        OPB_WE;
    logic [N-1:0] LED_OUT;
    logic        TICK_SQ;

    led_pattern_ctrl #(
        .N_LED      (N),
        .DIV_WIDTH  (32),
        .DEFAULT_DIV(32'(DEF_DIV)),
        .PWM_WIDTH  (4),
        .MANUAL_RST (32'h2AA)
    ) dut (
        .OPB_CLK (OPB_CLK),
        .OPB_RST (OPB_RST),
        .OPB_DI  (OPB_DI),
        .OPB_DO  (OPB_DO),
        .OPB_ADDR(OPB_ADDR),
        .OPB_RE  (OPB_RE),
        .OPB_WE  (OPB_WE),
        .LED_OUT (LED_OUT),
        .TICK_SQ (TICK_SQ)
    );

    initial OPB_CLK = 1'b0;
    always #5 OPB_CLK = ~OPB_CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [1:0]  m_mode;
    logic        m_en;
    logic [31:0] m_div;
    logic [3:0]  m_man, m_inv, m_duty, m_led;
    logic [31:0] m_tcnt;
    logic        m_sq;
    logic        m_ph;
    longint      m_since;   // cycles since the last tick or divider restart
    int          m_k;       // chase steps taken since the last restart
    int          m_cyc;     // clock edges since reset

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 2'd0; m_en = 1'b1; m_div = 32'(DEF_DIV);
        m_man = 4'hA; m_inv = 4'h0; m_duty = 4'hF; m_led = 4'h0;
        m_tcnt = 32'd0; m_sq = 1'b0; m_ph = 1'b0;
        m_since = 0; m_k = 0; m_cyc = 0;
    endtask

    // Bouncing chase folds the step count onto 0..N-1..0 with period 2(N-1).
    function automatic int model_pos();
        int r;
        if (N == 1) return 0;
        r = m_k % (2 * (N - 1));
        return (r <= N - 1) ? r : 2 * (N - 1) - r;
    endfunction

    function automatic logic model_dir();
        if (N == 1) return 1'b0;
        return (m_k % (2 * (N - 1))) >= (N - 1);
    endfunction

    function automatic logic [3:0] model_pattern();
        logic [3:0] one;
        one = 4'b0001;
        case (m_mode)
            2'd0:    return one << model_pos();
            2'd1:    return m_man;
            2'd2:    return m_ph ? 4'b1010 : 4'b0101;
            default: return m_ph ? 4'b1111 : 4'b0000;
        endcase
    endfunction

    // One clock edge with an optional write, then compare the outputs.
    task automatic step(input logic we, input logic [2:0] addr, input logic [31:0] data);
        logic   tick, gate;
        longint per;
        OPB_WE = we; OPB_ADDR = addr; OPB_DI = data; OPB_RE = 1'b0;

        per  = (m_div <= 32'd1) ? 1 : longint'(m_div);
        tick = !(we && addr == 3'd1) && (m_since + 1 == per);
        gate = (m_duty == 4'hF) || ((m_cyc % 16) < int'(m_duty));
        m_led = (model_pattern() & {4{m_en & gate}}) ^ m_inv;

        m_since = ((we && addr == 3'd1) || tick) ? 0 : m_since + 1;
        if (tick) begin
            m_tcnt = m_tcnt + 32'd1;
            m_sq   = ~m_sq;
        end
        if (we && addr == 3'd0 && data[1:0] != m_mode) begin
            m_k  = 0;
            m_ph = 1'b0;
        end else if (tick && m_en) begin
            if (m_mode == 2'd0)      m_k = m_k + 1;
            else if (m_mode >= 2'd2) m_ph = ~m_ph;
        end
        if (we) begin
            case (addr)
                3'd0: begin m_mode = data[1:0]; m_en = data[2]; end
                3'd1: m_div  = data;
                3'd4: m_man  = data[3:0];
                3'd5: m_inv  = data[3:0];
                3'd6: m_duty = data[3:0];
                default: ;
            endcase
        end
        m_cyc++;

        @(posedge OPB_CLK);
        #1;
        check("led_out", 32'(LED_OUT), 32'(m_led));
        check("tick_sq", 32'(TICK_SQ), 32'(m_sq));
        OPB_WE = 1'b0;
    endtask

    // Combinational register read, compared against the model.
    task automatic rd(input logic [2:0] addr);
        logic [31:0] exp;
        string       tag;
        case (addr)
            3'd0: begin exp = {29'd0, m_en, m_mode};                        tag = "rd_cntrl";   end
            3'd1: begin exp = m_div;                                        tag = "rd_clkdiv";  end
            3'd2: begin exp = 32'(model_pattern());                         tag = "rd_pattern"; end
            3'd3: begin exp = {23'd0, model_dir(), 8'(model_pos())};        tag = "rd_state";   end
            3'd4: begin exp = 32'(m_man);                                   tag = "rd_manual";  end
            3'd5: begin exp = 32'(m_inv);                                   tag = "rd_invert";  end
            3'd6: begin exp = 32'(m_duty);                                  tag = "rd_duty";    end
            default: begin exp = m_tcnt;                                    tag = "rd_tickcnt"; end
        endcase
        OPB_ADDR = addr;
        OPB_RE   = 1'b1;
        #1;
        check(tag, OPB_DO, exp);
        OPB_RE = 1'b0;
    endtask

    int          hi;
    logic [31:0] saved_tcnt;
    logic [2:0]  ra;
    logic [31:0] rdat;

    initial begin
        OPB_RST = 1'b1;
        OPB_WE = 1'b0; OPB_RE = 1'b0; OPB_ADDR = 3'd0; OPB_DI = 32'd0;
        model_reset();

        // Reset state
        repeat (2) @(posedge OPB_CLK);
        #1;
        check("rst_led", 32'(LED_OUT), 32'd0);
        check("rst_sq", 32'(TICK_SQ), 32'd0);
        rd(3'd0); rd(3'd1); rd(3'd3); rd(3'd4); rd(3'd5); rd(3'd6); rd(3'd7);
        OPB_ADDR = 3'd1; OPB_RE = 1'b0;
        #1;
        check("do_idle_zero", OPB_DO, 32'd0);
        OPB_RST = 1'b0;

        // First edge out of reset drives the chase head at position 0
        step(1'b0, 3'd0, 32'd0);
        check("first_edge_led", 32'(LED_OUT), 32'd1);

        // Chase with CLKDIV=3 for 18 clocks
        step(1'b1, 3'd1, 32'd3);
        for (int i = 0; i < 18; i++) step(1'b0, 3'd0, 32'd0);
        rd(3'd7);
        OPB_ADDR = 3'd7; OPB_RE = 1'b1;
        #1;
        check("tickcnt_after_18", OPB_DO, 32'd6);
        OPB_RE = 1'b0;
        rd(3'd3);

        // Manual pattern with inversion; RO write is ignored
        step(1'b1, 3'd4, 32'h5);
        step(1'b1, 3'd0, 32'h5);
        step(1'b1, 3'd5, 32'hF);
        step(1'b1, 3'd7, 32'h1234);
        check("manual_inverted", 32'(LED_OUT), 32'hA);
        rd(3'd2); rd(3'd7);

        // ALT then BLINK at CLKDIV=2
        step(1'b1, 3'd5, 32'h0);
        step(1'b1, 3'd1, 32'd2);
        step(1'b1, 3'd0, 32'h6);
        for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 32'd0);
        rd(3'd2);
        step(1'b1, 3'd0, 32'h7);
        for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 32'd0);
        rd(3'd2);

        // PWM dimming on a full manual pattern
        step(1'b1, 3'd0, 32'h5);
        step(1'b1, 3'd4, 32'hF);
        step(1'b1, 3'd6, 32'h4);
        step(1'b0, 3'd0, 32'd0);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 3'd0, 32'd0);
            if (LED_OUT == 4'hF) hi++;
        end
        check("pwm_duty4_on_count", 32'(hi), 32'd4);
        step(1'b1, 3'd6, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 32'd0);
        step(1'b1, 3'd6, 32'hF);
        for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 32'd0);

        // Disabled: pattern frozen, outputs dark, tick machinery still runs
        step(1'b1, 3'd0, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 32'd0);
        rd(3'd3); rd(3'd7);

        // Re-enable chase, run to pos=2 going up, then reset mid-operation
        step(1'b1, 3'd0, 32'h4);
        step(1'b1, 3'd1, 32'd3);
        for (int i = 0; i < 40 && !(model_pos() == 2 && !model_dir()); i++)
            step(1'b0, 3'd0, 32'd0);
        rd(3'd3);
        OPB_RST = 1'b1;
        model_reset();
        #1;
        check("async_rst_led", 32'(LED_OUT), 32'd0);
        rd(3'd1); rd(3'd7); rd(3'd3);
        #1;
        OPB_RST = 1'b0;
        step(1'b0, 3'd0, 32'd0);
        check("post_rst_led", 32'(LED_OUT), 32'd1);

        // CLKDIV write landing on a tick: no tick, divider restarts
        step(1'b1, 3'd1, 32'd3);
        step(1'b0, 3'd0, 32'd0);
        step(1'b0, 3'd0, 32'd0);
        saved_tcnt = m_tcnt;
        step(1'b1, 3'd1, 32'd5);
        rd(3'd7);
        OPB_ADDR = 3'd7; OPB_RE = 1'b1;
        #1;
        check("no_tick_on_div_write", OPB_DO, saved_tcnt);
        OPB_RE = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 32'd0);
        rd(3'd7); rd(3'd3);

        // Random register traffic
        for (int i = 0; i < 400; i++) begin
            ra = 3'($urandom_range(0, 7));
            case (ra)
                3'd0:    rdat = {29'd0, ($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3))};
                3'd1:    rdat = 32'($urandom_range(0, 4));
                default: rdat = $urandom();
            endcase
            step(($urandom_range(0, 2) == 0), ra, rdat);
            rd(3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
